// File: rtl/nanci_pe_mesh.sv
// Mesh processing element: per-cycle neighbour copy or compare-exchange on packed {addr,key} packets.
// Optional snake ordering for odd rows is enabled by defining NANCI_SNAKE_EN.
module nanci_pe_mesh #(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned DATA_WIDTH   = 3,
    parameter int unsigned SORT_CYCLES  = 4,
    parameter int unsigned FIRST_IN_ROW = 0,
    parameter int unsigned ROW_ODD      = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_init,
    input  logic [2:0]                       i_mode,
    input  logic                             i_op,
    input  logic                             i_keep_min,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_l,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_r,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_u,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_d,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
    output logic                             o_busy,
    output logic                             o_done
);
    localparam int unsigned W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [7:0] LastCnt = 8'(SORT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_t;

    state_t          state_q;
    logic [7:0]      cnt_q;
    logic [W-1:0]    pe_q;
    logic            busy_q;
    logic            done_q;

    logic [W-1:0]          cand;
    logic                  cand_vld;
    logic                  eff_keep_min;
    logic                  take;
    logic [DATA_WIDTH-1:0] own_key;
    logic [DATA_WIDTH-1:0] cand_key;

    always_comb begin
        cand     = pe_q;
        cand_vld = 1'b0;
        case (i_mode)
            3'd1: begin
                // A row-edge PE has no left neighbour, so left degenerates to hold.
                if (FIRST_IN_ROW == 0) begin
                    cand     = i_PE_l;
                    cand_vld = 1'b1;
                end
            end
            3'd2: begin
                cand     = i_PE_r;
                cand_vld = 1'b1;
            end
            3'd3: begin
                cand     = i_PE_u;
                cand_vld = 1'b1;
            end
            3'd4: begin
                cand     = i_PE_d;
                cand_vld = 1'b1;
            end
            default: begin
                cand     = pe_q;
                cand_vld = 1'b0;
            end
        endcase
    end

`ifdef NANCI_SNAKE_EN
    assign eff_keep_min = (ROW_ODD != 0) ? ~i_keep_min : i_keep_min;
`else
    logic unused_row_odd;
    assign unused_row_odd = ROW_ODD[0];
    assign eff_keep_min   = i_keep_min;
`endif

    assign own_key  = pe_q[DATA_WIDTH-1:0];
    assign cand_key = cand[DATA_WIDTH-1:0];

    // Ties fall through both comparisons, so the own packet is retained.
    always_comb begin
        take = 1'b0;
        if (cand_vld) begin
            if (i_op) begin
                take = 1'b1;
            end else if (eff_keep_min) begin
                take = (cand_key < own_key);
            end else begin
                take = (cand_key > own_key);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            pe_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        pe_q    <= i_init;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    state_q <= StRun;
                end
                StRun: begin
                    if (take) begin
                        pe_q <= cand;
                    end
                    if (cnt_q == LastCnt) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_PE   = pe_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule
